// File: rtl/puf_majority_vote.sv
// Majority vote over N repeated PUF evaluations, with optional per-bit instability mask.
// Define UNSTABLE_MASK_EN to build the UNSTABLE comparison logic; otherwise UNSTABLE is tied to 0.
module puf_majority_vote #(
  parameter int W     = 128,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [CNT_W-1:0] N_EVAL,
  output logic             REQ_EVAL,
  input  logic             DONE_IN,
  input  logic [W-1:0]     PUF_IN,
  output logic [W-1:0]     RESULT,
  output logic [W-1:0]     UNSTABLE,
  output logic             BUSY,
  output logic             VALID
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DECIDE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] ones_q [W];
  logic [CNT_W-1:0] ones_d [W];
  logic [W-1:0]     result_q, result_d;
  logic             valid_q, valid_d;
  logic             accept, eval, decide;

  // One extra bit keeps 2*ones from overflowing before the compare.
  function automatic logic majority(input logic [CNT_W-1:0] ones, input logic [CNT_W-1:0] n);
    logic [CNT_W:0] twice;
    twice = {ones, 1'b0};
    return twice > {1'b0, n};
  endfunction

  assign accept  = (state_q == IDLE) && START && (N_EVAL != '0);
  assign eval    = (state_q == WAIT) && DONE_IN;
  assign decide  = (state_q == DECIDE);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (eval) state_d = (cnt_inc == n_q) ? DECIDE : REQ;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    REQ_EVAL = (state_q == REQ);
    BUSY     = (state_q != IDLE);
  end

  always_comb begin
    n_d      = accept ? N_EVAL : n_q;
    cnt_d    = accept ? '0 : (eval ? cnt_inc : cnt_q);
    result_d = result_q;
    valid_d  = decide;
    for (int i = 0; i < W; i++) begin
      ones_d[i] = ones_q[i];
      if (accept)
        ones_d[i] = '0;
      else if (eval)
        ones_d[i] = ones_q[i] + CNT_W'(PUF_IN[i]);
      if (decide)
        result_d[i] = majority(ones_q[i], n_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < W; i++) ones_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      for (int i = 0; i < W; i++) ones_q[i] <= ones_d[i];
    end
  end

  assign RESULT = result_q;
  assign VALID  = valid_q;

`ifdef UNSTABLE_MASK_EN
  logic [W-1:0] unstable_q, unstable_d;

  // A bit is unstable when it was neither always 0 nor always 1.
  always_comb begin
    unstable_d = unstable_q;
    if (decide)
      for (int i = 0; i < W; i++)
        unstable_d[i] = (ones_q[i] != '0) && (ones_q[i] != n_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) unstable_q <= '0;
    else       unstable_q <= unstable_d;
  end

  assign UNSTABLE = unstable_q;
`else
  assign UNSTABLE = '0;
`endif

endmodule

// File: tb/tb_puf_majority_vote.sv
// Directed bench for puf_majority_vote: per-vote expectations queued at stimulus time, checked at VALID.
module tb_puf_majority_vote;
  localparam int W     = 128;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             START;
  logic [CNT_W-1:0] N_EVAL;
  logic             REQ_EVAL;
  logic             DONE_IN;
  logic [W-1:0]     PUF_IN;
  logic [W-1:0]     RESULT;
  logic [W-1:0]     UNSTABLE;
  logic             BUSY;
  logic             VALID;

  always #5 CLK = ~CLK;

  puf_majority_vote #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .N_EVAL(N_EVAL), .REQ_EVAL(REQ_EVAL),
    .DONE_IN(DONE_IN), .PUF_IN(PUF_IN), .RESULT(RESULT), .UNSTABLE(UNSTABLE),
    .BUSY(BUSY), .VALID(VALID)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] uns;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] pats [16];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_model(input int n);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      int c = 0;
      for (int k = 0; k < n; k++) c += int'(pats[k][i]);
      e.res[i] = (2 * c > n);
`ifdef UNSTABLE_MASK_EN
      e.uns[i] = (c != 0) && (c != n);
`else
      e.uns[i] = 1'b0;
`endif
    end
    sb.push_back(e);
  endtask

  // Drives one full vote, answering each REQ_EVAL with DONE_IN one cycle later.
  task automatic run_vote(input int n, input bit busy_start, input bit stray, input string tag);
    exp_t e;
    int   k    = 0;
    int   reqs = 0;
    bit   pend = 0;
    bit   got  = 0;
    push_model(n);
    START  = 1'b1;
    N_EVAL = n[CNT_W-1:0];
    @(negedge CLK);
    START = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      if (VALID) got = 1;
      else begin
        DONE_IN = 1'b0;
        START   = 1'b0;
        if (pend) begin
          DONE_IN = 1'b1;
          PUF_IN  = pats[k];
          k++;
          pend = 0;
        end else if (REQ_EVAL) begin
          reqs++;
          pend = 1;
          if (stray) begin
            DONE_IN = 1'b1;
            PUF_IN  = '1;
          end
        end
        if (busy_start && cyc == 3) begin
          START  = 1'b1;
          N_EVAL = 4'd7;
        end
        @(negedge CLK);
      end
    end
    DONE_IN = 1'b0;
    START   = 1'b0;
    chk({tag, "_valid_seen"}, W'(got), W'(1));
    chk({tag, "_req_pulses"}, W'(reqs), W'(n));
    e = sb.pop_front();
    chk({tag, "_result"}, RESULT, e.res);
    chk({tag, "_unstable"}, UNSTABLE, e.uns);
    @(negedge CLK);
    chk({tag, "_valid_pulse"}, W'(VALID), W'(0));
    chk({tag, "_idle_after"}, W'(BUSY), W'(0));
    chk({tag, "_result_hold"}, RESULT, e.res);
  endtask

  initial begin
    int reqs, valids, busys, dones;
    RESET   = 1'b1;
    START   = 1'b0;
    N_EVAL  = '0;
    DONE_IN = 1'b0;
    PUF_IN  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_result", RESULT, '0);
    chk("rst_unstable", UNSTABLE, '0);
    chk("rst_busy", W'(BUSY), W'(0));
    chk("rst_valid", W'(VALID), W'(0));
    chk("rst_req", W'(REQ_EVAL), W'(0));
    RESET = 1'b0;
    @(negedge CLK);

    // 3 of 5 evaluations all-ones
    for (int k = 0; k < 5; k++) pats[k] = (k < 3) ? '1 : '0;
    run_vote(5, 0, 0, "n5_3of5");

    // bit 0 stable high, bit 127 flips once
    pats[0] = W'(1);
    pats[1] = {1'b1, {(W-1){1'b0}}} | W'(1);
    pats[2] = W'(1);
    run_vote(3, 0, 0, "n3_bits");

    // even-N tie on bit 5, with stray DONE_IN in REQ cycles
    pats[0] = W'(1) << 5;
    pats[1] = W'(1) << 5;
    pats[2] = '0;
    pats[3] = '0;
    run_vote(4, 0, 1, "n4_tie");

    // START with N_EVAL=0 must be ignored
    START  = 1'b1;
    N_EVAL = '0;
    reqs = 0; valids = 0; busys = 0;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 8; c++) begin
      reqs   += int'(REQ_EVAL);
      valids += int'(VALID);
      busys  += int'(BUSY);
      @(negedge CLK);
    end
    chk("n0_req", W'(reqs), W'(0));
    chk("n0_valid", W'(valids), W'(0));
    chk("n0_busy", W'(busys), W'(0));

    // START with N_EVAL=7 while busy must not change N
    for (int k = 0; k < 16; k++) pats[k] = rand_w();
    run_vote(3, 1, 0, "busy_start");

    run_vote(7, 0, 1, "n7_rand");
    run_vote(15, 0, 0, "n15_rand");

    // reset after the second DONE_IN of an N=5 vote
    for (int k = 0; k < 5; k++) pats[k] = rand_w();
    START  = 1'b1;
    N_EVAL = 4'd5;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    valids = 0;
    for (int c = 0; c < 40 && dones < 2; c++) begin
      DONE_IN = 1'b0;
      if (REQ_EVAL) begin
        @(negedge CLK);
        DONE_IN = 1'b1;
        PUF_IN  = pats[dones];
        dones++;
      end
      valids += int'(VALID);
      @(negedge CLK);
    end
    chk("abort_dones", W'(dones), W'(2));
    DONE_IN = 1'b0;
    RESET   = 1'b1;
    @(negedge CLK);
    chk("abort_result", RESULT, '0);
    chk("abort_unstable", UNSTABLE, '0);
    chk("abort_busy", W'(BUSY), W'(0));
    chk("abort_req", W'(REQ_EVAL), W'(0));
    RESET = 1'b0;
    busys = 0;
    for (int c = 0; c < 20; c++) begin
      valids += int'(VALID);
      busys  += int'(BUSY);
      @(negedge CLK);
    end
    chk("abort_no_valid", W'(valids), W'(0));
    chk("abort_stays_idle", W'(busys), W'(0));

    // single evaluation returns the response unchanged
    pats[0] = rand_w();
    run_vote(1, 0, 0, "n1_after_rst");
    chk("n1_passthru", RESULT, pats[0]);
    chk("n1_stable", UNSTABLE, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
